// File: rtl/demux_stream_1ton.sv
// 1-to-N registered stream demux, addressed or round-robin; beats land one cycle after accept.
// in_ready is combinational on the target channel's free state; out-of-range selects are sunk.
module demux_stream_1ton #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 mode,
    output logic [N-1:0]         out_valid,
    input  logic [N-1:0]         out_ready,
    output logic [N*WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]     rr_ptr,
    output logic                 sel_err
);

    // One extra bit so N itself is representable when N == 2**SEL_W
    localparam logic [SEL_W:0]   N_EXT = (SEL_W+1)'(N);
    localparam logic [SEL_W-1:0] LAST  = SEL_W'(N - 1);

    logic [SEL_W-1:0] tgt;
    logic             tgt_bad;
    logic [N-1:0]     hit;
    logic [N-1:0]     free;
    logic [N-1:0]     wr;
    logic             accept;
    logic             mode_q;
    logic             mode_rise;
    logic [SEL_W-1:0] rr_inc;

    assign tgt     = mode ? rr_ptr : sel;
    assign tgt_bad = ({1'b0, tgt} >= N_EXT);
    assign free    = ~out_valid | out_ready;

    always_comb begin
        hit = '0;
        for (int k = 0; k < N; k++) begin
            hit[k] = (tgt == SEL_W'(k));
        end
    end

    assign in_ready  = tgt_bad | (|(hit & free));
    assign accept    = in_valid & in_ready;
    assign wr        = hit & {N{accept}};
    assign mode_rise = mode & ~mode_q;
    assign rr_inc    = (rr_ptr == LAST) ? '0 : rr_ptr + SEL_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= 1'b0;
            rr_ptr  <= '0;
            sel_err <= 1'b0;
        end else begin
            mode_q  <= mode;
            sel_err <= accept & tgt_bad;
            // Entering scan mode restarts the scan; this wins over the accept increment
            if (mode_rise) begin
                rr_ptr <= '0;
            end else if (accept && mode) begin
                rr_ptr <= rr_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= '0;
            out_data  <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (wr[k]) begin
                    out_valid[k]               <= 1'b1;
                    out_data[k*WIDTH +: WIDTH] <= in_data;
                end else if (out_ready[k]) begin
                    out_valid[k] <= 1'b0;
                end
            end
        end
    end

endmodule
